seven_segment_scanner: RTL and testbench

//  Downstream of the seven-segment controller. Takes its four decoded digit

---
 rtl/seven_segment_scanner_if.sv | 32 +++
 rtl/seven_segment_scanner.sv | 94 +++++++++
 tb/tb_seven_segment_scanner.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// CPU I/O bus, decoded digit patterns and multiplexed display outputs
// shared between the seven-segment scanner and whatever drives it.
`default_nettype none

interface seven_segment_scanner_if;
  logic [31:0] addressBus;
  logic [7:0]  dataBusIn;
  logic        readWrite;
  logic        mio;
  logic        enable;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic [6:0]  segments;
  logic [3:0]  digitSelect;
  logic        frameStart;

  modport master (
    output addressBus, dataBusIn, readWrite, mio, enable,
    output hex0, hex1, hex2, hex3,
    input  segments, digitSelect, frameStart
  );

  modport slave (
    input  addressBus, dataBusIn, readWrite, mio, enable,
    input  hex0, hex1, hex2, hex3,
    output segments, digitSelect, frameStart
  );
endinterface

`default_nettype wire

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 4-digit scanner with frame-synchronous snapshot,
// 16-phase PWM dimming and a CPU-writable brightness / blank-mask byte.
`default_nettype none

module seven_segment_scanner #(
  parameter int          CLOCK_DIVIDER      = 12500,
  parameter logic [31:0] BRIGHTNESS_ADDRESS = 32'hFFFF_FF12
) (
  input  wire logic             clock,
  input  wire logic             reset,
  seven_segment_scanner_if.slave bus
);

  localparam int PRESCALE_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(CLOCK_DIVIDER - 1);

  logic [PRESCALE_W-1:0] prescaler;
  logic [3:0]            phase;
  logic [1:0]            digit;
  logic [3:0]            brightness;
  logic [3:0]            blank_mask;
  logic [6:0]            frame [4];
  logic                  load_pending;
  logic [6:0]            segments_reg;
  logic [3:0]            digit_select_reg;
  logic                  frame_start_reg;

  logic [6:0] hex [4];
  logic       tick;
  logic       snapshot;
  logic       ctrl_write;
  logic       lit;

  always_comb begin
    hex[0]     = bus.hex0;
    hex[1]     = bus.hex1;
    hex[2]     = bus.hex2;
    hex[3]     = bus.hex3;
    tick       = (prescaler == PRESCALE_LAST);
    // load_pending forces one snapshot right after reset so the first frame is real data
    snapshot   = (tick && (phase == 4'hF) && (digit == 2'd3)) || load_pending;
    ctrl_write = !bus.readWrite && !bus.mio && bus.enable &&
                 (bus.addressBus == BRIGHTNESS_ADDRESS);
    lit        = (phase < brightness) && !blank_mask[digit];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler        <= '0;
      phase            <= 4'h0;
      digit            <= 2'd0;
      brightness       <= 4'hF;
      blank_mask       <= 4'h0;
      for (int i = 0; i < 4; i++) frame[i] <= 7'h7F;
      load_pending     <= 1'b1;
      segments_reg     <= 7'h7F;
      digit_select_reg <= 4'hF;
      frame_start_reg  <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        phase <= phase + 4'h1;
        if (phase == 4'hF) digit <= digit + 2'd1;
      end

      if (snapshot) begin
        for (int i = 0; i < 4; i++) frame[i] <= hex[i];
      end
      load_pending    <= 1'b0;
      frame_start_reg <= snapshot;

      if (ctrl_write) begin
        brightness <= bus.dataBusIn[3:0];
        blank_mask <= bus.dataBusIn[7:4];
      end

      // Gating uses pre-edge state, so new brightness/mask take effect one cycle later
      if (lit) begin
        segments_reg     <= frame[digit];
        digit_select_reg <= ~(4'b0001 << digit);
      end else begin
        segments_reg     <= 7'h7F;
        digit_select_reg <= 4'hF;
      end
    end
  end

  assign bus.segments    = segments_reg;
  assign bus.digitSelect = digit_select_reg;
  assign bus.frameStart  = frame_start_reg;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner against a slot-arithmetic
// reference model derived from the elapsed clock count since reset release.
`default_nettype none

module tb_seven_segment_scanner;

  localparam int          DIV  = 2;
  localparam logic [31:0] ADDR = 32'hFFFF_FF12;

  logic clock = 1'b0;
  logic reset = 1'b1;
  seven_segment_scanner_if bus_if ();

  seven_segment_scanner #(
    .CLOCK_DIVIDER      (DIV),
    .BRIGHTNESS_ADDRESS (ADDR)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit run_checks = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: everything follows from n, the number of edges since release
  int         n;
  logic [3:0] m_bright;
  logic [3:0] m_mask;
  logic [6:0] m_frame [4];
  logic [6:0] exp_seg;
  logic [3:0] exp_sel;
  logic       exp_fs;

  always @(posedge clock or posedge reset) begin
    int  slot, ph, dg;
    bit  on, snap;
    if (reset) begin
      n        = 0;
      m_bright = 4'hF;
      m_mask   = 4'h0;
      for (int i = 0; i < 4; i++) m_frame[i] = 7'h7F;
      exp_seg  = 7'h7F;
      exp_sel  = 4'hF;
      exp_fs   = 1'b0;
    end else begin
      slot    = n / DIV;
      ph      = slot % 16;
      dg      = (slot / 16) % 4;
      on      = (ph < int'(m_bright)) && !m_mask[dg];
      exp_seg = on ? m_frame[dg] : 7'h7F;
      exp_sel = on ? ~(4'b0001 << dg) : 4'hF;
      snap    = (n == 0) || ((n % DIV == DIV - 1) && (slot % 64 == 63));
      exp_fs  = snap;
      if (snap) begin
        m_frame[0] = bus_if.hex0;
        m_frame[1] = bus_if.hex1;
        m_frame[2] = bus_if.hex2;
        m_frame[3] = bus_if.hex3;
      end
      if (bus_if.enable && !bus_if.readWrite && !bus_if.mio && bus_if.addressBus == ADDR) begin
        m_bright = bus_if.dataBusIn[3:0];
        m_mask   = bus_if.dataBusIn[7:4];
      end
      n++;
    end
  end

  always @(negedge clock) begin
    if (run_checks) begin
      check("segments", 32'(bus_if.segments), 32'(exp_seg));
      check("digitSelect", 32'(bus_if.digitSelect), 32'(exp_sel));
      check("frameStart", 32'(bus_if.frameStart), 32'(exp_fs));
      check("one_hot", 32'($countones(~bus_if.digitSelect) <= 1), 32'd1);
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic bus_cycle(input logic [31:0] a, input logic [7:0] d,
                           input logic rw, input logic m, input logic en);
    @(negedge clock);
    bus_if.addressBus = a;
    bus_if.dataBusIn  = d;
    bus_if.readWrite  = rw;
    bus_if.mio        = m;
    bus_if.enable     = en;
    @(negedge clock);
    bus_if.enable     = 1'b0;
    bus_if.readWrite  = 1'b1;
    bus_if.mio        = 1'b1;
  endtask

  initial begin
    int r;
    bus_if.addressBus = 32'h0;
    bus_if.dataBusIn  = 8'h00;
    bus_if.readWrite  = 1'b1;
    bus_if.mio        = 1'b1;
    bus_if.enable     = 1'b0;
    bus_if.hex0 = 7'h40;
    bus_if.hex1 = 7'h79;
    bus_if.hex2 = 7'h79;
    bus_if.hex3 = 7'h30;
    idle(3);
    run_checks = 1'b1;
    reset = 1'b0;
    idle(300);

    bus_cycle(ADDR, 8'h03, 1'b0, 1'b0, 1'b1);
    idle(260);
    bus_cycle(ADDR, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(150);
    bus_cycle(ADDR, 8'h2F, 1'b0, 1'b0, 1'b1);
    idle(260);
    bus_cycle(ADDR, 8'h0F, 1'b0, 1'b0, 1'b1);
    idle(70);
    bus_if.hex2 = 7'h24;
    idle(260);

    bus_cycle(ADDR,      8'h01, 1'b0, 1'b1, 1'b1);
    bus_cycle(ADDR,      8'h01, 1'b1, 1'b0, 1'b1);
    bus_cycle(ADDR + 1,  8'h01, 1'b0, 1'b0, 1'b1);
    bus_cycle(ADDR,      8'h01, 1'b0, 1'b0, 1'b0);
    idle(260);

    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      bus_if.enable    = 1'b0;
      bus_if.readWrite = 1'b1;
      bus_if.mio       = 1'b1;
      r = $urandom_range(0, 39);
      if (r <= 1) begin
        bus_if.addressBus = (r == 0) ? ADDR : ADDR + 32'($urandom_range(1, 3));
        bus_if.dataBusIn  = 8'($urandom);
        bus_if.readWrite  = ($urandom_range(0, 3) == 0);
        bus_if.mio        = ($urandom_range(0, 3) == 0);
        bus_if.enable     = 1'b1;
      end else if (r <= 4) begin
        case ($urandom_range(0, 3))
          0:       bus_if.hex0 = 7'($urandom);
          1:       bus_if.hex1 = 7'($urandom);
          2:       bus_if.hex2 = 7'($urandom);
          default: bus_if.hex3 = 7'($urandom);
        endcase
      end
    end
    @(negedge clock);
    bus_if.enable = 1'b0;
    bus_cycle(ADDR, 8'h0F, 1'b0, 1'b0, 1'b1);
    idle(45);

    // Assert reset between edges and look before the next clock edge
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_segments", 32'(bus_if.segments), 32'h7F);
    check("async_digitSelect", 32'(bus_if.digitSelect), 32'hF);
    check("async_frameStart", 32'(bus_if.frameStart), 32'h0);
    idle(3);
    reset = 1'b0;
    idle(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
